// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, FSM states, round constants and
// the GF(2^8) helpers used by MixColumns.
package aes_pkg;

    localparam logic [3:0] ROUNDS = 4'd10;

    typedef enum logic {
        IDLE,
        RUN
    } aes_state_t;

    // Round constants, indexed by the round being computed (1..10)
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] value;
        case (round)
            4'd1:    value = 8'h01;
            4'd2:    value = 8'h02;
            4'd3:    value = 8'h04;
            4'd4:    value = 8'h08;
            4'd5:    value = 8'h10;
            4'd6:    value = 8'h20;
            4'd7:    value = 8'h40;
            4'd8:    value = 8'h80;
            4'd9:    value = 8'h1B;
            4'd10:   value = 8'h36;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One column through the {02,03,01,01} circulant; byte 0 sits in [31:24]
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a constant lookup table; purely combinational.
module aes_sbox (
    input  logic [7:0] plain_byte,
    output logic [7:0] sub_byte
);

    // Entry for input x occupies bits [2047-8x -: 8], i.e. {~x, 3'b111} down
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub_byte = SBOX_TABLE[{~plain_byte, 3'b111} -: 8];

endmodule

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption: one round per clock with the round key
// expanded on the fly alongside the state.
module aes128_encrypt_core
    import aes_pkg::*;
(
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    aes_state_t   fsm_q;
    logic [3:0]   round_q;
    logic [127:0] state_q;
    logic [127:0] rkey_q;

    logic [127:0] sub_bytes;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] round_out;
    logic [127:0] next_key;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  w0_next, w1_next, w2_next, w3_next;

    // Byte i of a 128-bit word lives at [127-8i -: 8]; state row r, column c is byte 4c+r
    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .plain_byte (state_q[127-8*i -: 8]),
            .sub_byte   (sub_bytes[127-8*i -: 8])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end

    assign rot_word = {rkey_q[23:0], rkey_q[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub_word
        aes_sbox u_sbox (
            .plain_byte (rot_word[31-8*i -: 8]),
            .sub_byte   (sub_word[31-8*i -: 8])
        );
    end

    assign w0_next  = rkey_q[127:96] ^ sub_word ^ {rcon(round_q), 24'h0};
    assign w1_next  = rkey_q[95:64] ^ w0_next;
    assign w2_next  = rkey_q[63:32] ^ w1_next;
    assign w3_next  = rkey_q[31:0]  ^ w2_next;
    assign next_key = {w0_next, w1_next, w2_next, w3_next};

    // The last round skips MixColumns
    assign round_out = ((round_q == ROUNDS) ? shifted : mixed) ^ next_key;

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm_q              <= IDLE;
            round_q            <= 4'd0;
            state_q            <= '0;
            rkey_q             <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            AES_data_out_valid <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (AES_en) begin
                        state_q <= AES_data_in ^ AES_key_in;
                        rkey_q  <= AES_key_in;
                        round_q <= 4'd1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    rkey_q  <= next_key;
                    if (round_q == ROUNDS) begin
                        AES_data_out       <= round_out;
                        AES_data_out_valid <= 1'b1;
                        round_q            <= 4'd0;
                        fsm_q              <= IDLE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    round_q <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core against a byte-array AES model
// whose S-box is derived from the GF(2^8) inverse and affine transform.
module tb_aes128_encrypt_core;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         data_out_valid;

    int total = 0;
    int bad   = 0;

    logic [7:0] sbox_ref [256];

    aes128_encrypt_core dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_en             (en),
        .AES_data_in        (data_in),
        .AES_key_in         (key_in),
        .AES_data_out       (data_out),
        .AES_data_out_valid (data_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int v = 0; v < 256; v++) begin
            b = 8'(v);
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, b);
            end
            sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] ct;
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbox_ref[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[4*c+r] = tmp[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) begin
                t = w[4*rnd + i/4];
                st[i] = st[i] ^ t[31-8*(i%4) -: 8];
            end
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
        return ct;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [127:0] d, input logic [127:0] k);
        en      = e;
        data_in = d;
        key_in  = k;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Starts one block, measures capture-to-valid latency, checks result and pulse width
    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] d,
                             input logic [127:0] expected, input bit scramble);
        int lat;
        lat = 0;
        applyStimulus(1'b1, d, k);
        tick();
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            if (scramble) applyStimulus(c < 5, rand128(), rand128());
            else          applyStimulus(1'b0, d, k);
            tick();
            if (data_out_valid === 1'b1) lat = c;
        end
        checkOutput({tag, "_latency"}, 128'(lat), 128'd10);
        checkOutput({tag, "_data"}, data_out, expected);
        applyStimulus(1'b0, rand128(), rand128());
        tick();
        checkOutput({tag, "_pulse_end"}, {127'b0, data_out_valid}, 128'd0);
        checkOutput({tag, "_hold"}, data_out, expected);
    endtask

    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_DATA = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_DATA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        logic [127:0] k;
        logic [127:0] d;
        logic [127:0] expected;

        build_sbox();
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0);
        #2;
        checkOutput("reset_data", data_out, 128'd0);
        checkOutput("reset_valid", {127'b0, data_out_valid}, 128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idle_valid", {127'b0, data_out_valid}, 128'd0);

        $display("[TB] known-answer vectors");
        run_block("app_b", B_KEY, B_DATA, B_CT, 1'b0);
        run_block("app_c1", C_KEY, C_DATA, C_CT, 1'b0);
        run_block("all_zero", 128'd0, 128'd0, Z_CT, 1'b0);

        $display("[TB] enable held high with constant inputs");
        k = rand128();
        d = rand128();
        expected = aes_ref(k, d);
        applyStimulus(1'b1, d, k);
        for (int n = 1; n <= 51; n++) begin
            tick();
            checkOutput("hold_valid", {127'b0, data_out_valid}, {127'b0, (n % 11) == 0});
            if ((n % 11) == 0) checkOutput("hold_data", data_out, expected);
            if (n == 51) applyStimulus(1'b0, d, k);
        end
        // The block started at the 45th edge is still in flight and completes at the 55th
        for (int n = 52; n <= 70; n++) begin
            tick();
            checkOutput("drop_valid", {127'b0, data_out_valid}, {127'b0, n == 55});
            checkOutput("drop_data", data_out, expected);
            applyStimulus(1'b0, rand128(), rand128());
        end

        $display("[TB] inputs scrambled during run");
        for (int i = 0; i < 3; i++) begin
            k = rand128();
            d = rand128();
            run_block("scramble", k, d, aes_ref(k, d), 1'b1);
        end

        $display("[TB] reset at round five");
        applyStimulus(1'b1, B_DATA, B_KEY);
        tick();
        applyStimulus(1'b0, B_DATA, B_KEY);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_data", data_out, 128'd0);
        checkOutput("midreset_valid", {127'b0, data_out_valid}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midreset_hold_valid", {127'b0, data_out_valid}, 128'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("post_reset_quiet", {127'b0, data_out_valid}, 128'd0);
        end
        run_block("post_reset_app_b", B_KEY, B_DATA, B_CT, 1'b0);

        $display("[TB] random vectors");
        for (int i = 0; i < 6; i++) begin
            k = rand128();
            d = rand128();
            run_block("random", k, d, aes_ref(k, d), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
